// File: rtl/writeback_arbiter.sv
// Merges the in-order pipeline writeback (port A, always wins) with a queued long-latency
// writeback (port B) onto the single register-file write port, with WAW squash and starvation relief.
module writeback_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteD,
  output logic [31:0] busy_mask,
  output logic        stall_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [CW-1:0] LIMIT    = CW'(STARVE_LIMIT);

  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [DEPTH-1:0] ent_valid;
  logic [4:0]       ent_reg  [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic             from_b;
  logic [CW-1:0]    starve_cnt;

  logic [PW-1:0] count, lead, rd_adv;
  logic [AW-1:0] head_idx, wr_idx;
  logic          has_live, full, a_win, pop, push;
  logic [CW-1:0] starve_next;
  logic          stall_next;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == FULL_CNT);
  assign b_ready = rst_n && !full;
  assign wr_idx  = wr_ptr[AW-1:0];
  assign a_win   = a_valid && (a_reg != 5'd0);
  assign push    = b_valid && b_ready && (b_reg != 5'd0);
  assign pop     = !a_win && has_live;
  // Squashed slots ahead of the first live entry are reclaimed every cycle, so they never cost an output cycle.
  assign rd_adv  = lead + PW'(pop);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    has_live = 1'b0;
    head_idx = '0;
    lead     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!has_live && (PW'(i) < count)) begin
        if (ent_valid[rd_ptr[AW-1:0] + AW'(i)]) begin
          has_live = 1'b1;
          head_idx = rd_ptr[AW-1:0] + AW'(i);
        end else begin
          lead = lead + 1'b1;
        end
      end
    end
  end

  always_comb begin
    starve_next = '0;
    stall_next  = 1'b0;
    if (!pop && has_live) begin
      starve_next = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
      stall_next  = stall_o || (starve_next >= LIMIT);
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) busy_mask[ent_reg[i]] = 1'b1;
    end
    if (RegWrite && from_b) busy_mask[WriteReg] = 1'b1;
    busy_mask[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      ent_valid  <= '0;
      RegWrite   <= 1'b0;
      WriteReg   <= '0;
      WriteD     <= '0;
      from_b     <= 1'b0;
      starve_cnt <= '0;
      stall_o    <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + rd_adv;
      for (int i = 0; i < DEPTH; i++) begin
        if (a_win && ent_reg[i] == a_reg) ent_valid[i] <= 1'b0;
      end
      if (pop) ent_valid[head_idx] <= 1'b0;
      // The entry enqueued this edge is younger than the A write, so it is set after the squash.
      if (push) begin
        ent_valid[wr_idx] <= 1'b1;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (a_win) begin
        RegWrite <= 1'b1;
        WriteReg <= a_reg;
        WriteD   <= a_data;
        from_b   <= 1'b0;
      end else if (pop) begin
        RegWrite <= 1'b1;
        WriteReg <= ent_reg[head_idx];
        WriteD   <= ent_data[head_idx];
        from_b   <= 1'b1;
      end else begin
        RegWrite <= 1'b0;
        from_b   <= 1'b0;
      end
      starve_cnt <= starve_next;
      stall_o    <= stall_next;
    end
  end

  // NOTE: payload storage is not reset; ent_valid alone decides whether a slot holds anything.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg[wr_idx]  <= b_reg;
      ent_data[wr_idx] <= b_data;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_writeback_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_reg = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic [4:0]  b_reg = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteD;
  logic [31:0] busy_mask;
  logic        stall_o;

  int total = 0;
  int bad   = 0;

  writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteD(WriteD),
    .busy_mask(busy_mask), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: queue of accepted B writes, each either live or squashed.
  typedef struct {
    bit [4:0]  r;
    bit [31:0] d;
    bit        live;
  } ent_t;

  ent_t      q[$];
  bit        m_rw;
  bit [4:0]  m_wr;
  bit [31:0] m_wd;
  bit        m_fromb;
  int        m_starve;
  bit        m_stall;

  always @(posedge clk or negedge rst_n) begin : model
    bit   ready, alive, awin, popped;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_rw = 0; m_wr = 0; m_wd = 0; m_fromb = 0; m_starve = 0; m_stall = 0;
    end else begin
      ready  = (q.size() < DEPTH);
      alive  = 0;
      foreach (q[i]) if (q[i].live) alive = 1;
      awin   = a_valid && (a_reg != 0);
      popped = 0;
      while (q.size() > 0 && !q[0].live) void'(q.pop_front());
      if (awin) begin
        m_rw = 1; m_wr = a_reg; m_wd = a_data; m_fromb = 0;
        foreach (q[i]) if (q[i].r == a_reg) q[i].live = 0;
      end else if (alive) begin
        e = q.pop_front();
        m_rw = 1; m_wr = e.r; m_wd = e.d; m_fromb = 1; popped = 1;
      end else begin
        m_rw = 0; m_fromb = 0;
      end
      if (popped || !alive) begin
        m_starve = 0; m_stall = 0;
      end else begin
        m_starve++;
        if (m_starve >= STARVE_LIMIT) m_stall = 1;
      end
      if (b_valid && ready && b_reg != 0) q.push_back('{b_reg, b_data, 1'b1});
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] em;
    em = '0;
    foreach (q[i]) if (q[i].live) em[q[i].r] = 1'b1;
    if (m_rw && m_fromb) em[m_wr] = 1'b1;
    em[0] = 1'b0;
    check("m_RegWrite", 32'(RegWrite), 32'(m_rw));
    if (m_rw) begin
      check("m_WriteReg", 32'(WriteReg), 32'(m_wr));
      check("m_WriteD", WriteD, m_wd);
    end
    check("m_busy_mask", busy_mask, em);
    check("m_stall", 32'(stall_o), 32'(m_stall));
    check("m_b_ready", 32'(b_ready), 32'(rst_n && q.size() < DEPTH));
  end

  task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_RegWrite", 32'(RegWrite), 0);
    check("rst_b_ready", 32'(b_ready), 0);
    rst_n = 1'b1;
    #1 check("rel_b_ready", 32'(b_ready), 1);

    // A only
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0); tick();
    check("a_RegWrite", 32'(RegWrite), 1);
    check("a_WriteReg", 32'(WriteReg), 5);
    check("a_WriteD", WriteD, 32'hDEAD_BEEF);
    drive(1, 0, 32'h123, 0, 0, 0); tick();
    check("a0_RegWrite", 32'(RegWrite), 0);
    check("a0_WriteReg_hold", 32'(WriteReg), 5);

    // B drain
    drive(0, 0, 0, 1, 3, 32'h11); tick();
    check("b_wait_RegWrite", 32'(RegWrite), 0);
    check("b_busy3", busy_mask, 32'h8);
    drive(0, 0, 0, 1, 4, 32'h22); tick();
    check("b_r3_WriteReg", 32'(WriteReg), 3);
    check("b_r3_WriteD", WriteD, 32'h11);
    check("b_busy34", busy_mask, 32'h18);
    idle(); tick();
    check("b_r4_WriteReg", 32'(WriteReg), 4);
    check("b_busy4", busy_mask, 32'h10);
    tick();
    check("b_done_RegWrite", 32'(RegWrite), 0);
    check("b_busy0", busy_mask, 0);

    // Full FIFO under continuous A traffic
    drive(1, 1, 32'h100, 1, 10, 32'h10A); tick();
    drive(1, 1, 32'h101, 1, 11, 32'h10B); tick();
    check("full_b_ready", 32'(b_ready), 0);
    drive(1, 1, 32'h102, 1, 12, 32'h10C); tick();
    check("full_b_ready2", 32'(b_ready), 0);
    drive(0, 0, 0, 1, 12, 32'h10C); tick();
    check("full_pop_WriteReg", 32'(WriteReg), 10);
    check("full_after_pop_ready", 32'(b_ready), 1);
    tick();
    check("full_r11", 32'(WriteReg), 11);
    idle(); tick();
    check("full_r12_WriteReg", 32'(WriteReg), 12);
    check("full_r12_WriteD", WriteD, 32'h10C);
    tick();

    // WAW squash
    drive(0, 0, 0, 1, 7, 32'hAA); tick();
    drive(1, 7, 32'hBB, 0, 0, 0); tick();
    check("waw_WriteReg", 32'(WriteReg), 7);
    check("waw_WriteD", WriteD, 32'hBB);
    idle(); tick();
    check("waw_no_rewrite", 32'(RegWrite), 0);
    check("waw_busy", busy_mask, 0);
    tick();
    check("waw_no_rewrite2", 32'(RegWrite), 0);

    // Same-cycle A and B to one register: B is younger and survives
    drive(1, 9, 32'hCC, 1, 9, 32'hDD); tick();
    check("same_A", WriteD, 32'hCC);
    idle(); tick();
    check("same_B_RegWrite", 32'(RegWrite), 1);
    check("same_B_WriteD", WriteD, 32'hDD);
    tick();

    // Starvation relief
    drive(1, 2, 32'h0, 1, 6, 32'h66); tick();
    for (int i = 0; i < 7; i++) begin
      drive(1, 2, 32'(i), 0, 0, 0); tick();
    end
    check("starve_7", 32'(stall_o), 0);
    drive(1, 2, 32'h7, 0, 0, 0); tick();
    check("starve_8", 32'(stall_o), 1);
    drive(1, 2, 32'h8, 0, 0, 0); tick();
    check("starve_hold", 32'(stall_o), 1);
    check("starve_a_wins", WriteD, 32'h8);
    idle(); tick();
    check("starve_pop_WriteReg", 32'(WriteReg), 6);
    check("starve_pop_WriteD", WriteD, 32'h66);
    check("starve_release", 32'(stall_o), 0);
    tick();

    // Mixed traffic: frequent register collisions, r0 on both ports
    for (int i = 0; i < 40; i++) begin
      drive((i % 3) != 0, 5'((i * 7) % 6), 32'(32'h1000 + i),
            (i % 2) == 0, 5'((i * 5) % 6), 32'(32'h2000 + i));
      tick();
    end
    idle();
    repeat (4) tick();

    // Reset with two entries queued
    drive(1, 1, 32'h300, 1, 20, 32'h320); tick();
    drive(1, 1, 32'h301, 1, 21, 32'h321); tick();
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_RegWrite", 32'(RegWrite), 0);
    check("mid_rst_WriteReg", 32'(WriteReg), 0);
    check("mid_rst_WriteD", WriteD, 0);
    check("mid_rst_busy", busy_mask, 0);
    check("mid_rst_stall", 32'(stall_o), 0);
    check("mid_rst_b_ready", 32'(b_ready), 0);
    idle();
    repeat (2) tick();
    rst_n = 1'b1;
    #1 check("mid_rel_b_ready", 32'(b_ready), 1);
    tick();
    check("mid_no_stale", 32'(RegWrite), 0);
    tick();
    check("mid_no_stale2", 32'(RegWrite), 0);
    check("mid_busy_clear", busy_mask, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
